playfield_grid_writer: RTL and testbench



---
 rtl/playfield_grid_writer.sv | 174 +++++++++++++++++
 tb/tb_playfield_grid_writer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_grid_writer.sv
// Playfield cell store: a flop-based COLS x ROWS grid of {occupied, colour} cells, updated
// through a single-command valid/ready port and read combinationally by the colour mapper.
module playfield_grid_writer #(
    parameter int COLS    = 10,
    parameter int ROWS    = 18,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [3:0]         cmd_x,
    input  logic [4:0]         cmd_y,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               done,
    output logic               err,
    output logic               busy,
    input  logic [3:0]         rd_x,
    input  logic [4:0]         rd_y,
    output logic               rd_occupied,
    output logic [COLOR_W-1:0] rd_color,
    output logic [ROWS-1:0]    full_rows,
    output logic [7:0]         lines_total
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_ERASE    = 2'b01;
    localparam logic [1:0] OP_CLEAR    = 2'b10;
    localparam logic [3:0] COLS_L      = 4'(COLS);
    localparam logic [4:0] ROWS_L      = 5'(ROWS);
    localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);

    typedef logic [COLS-1:0]               occ_row_t;
    typedef logic [COLS-1:0][COLOR_W-1:0]  col_row_t;

    state_t               state_q, state_d;
    logic [4:0]           ptr_q, ptr_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [7:0]           lines_q, lines_d;
    occ_row_t [ROWS-1:0]  occ_q, occ_d;
    col_row_t [ROWS-1:0]  col_q, col_d;

    logic cmd_x_ok;
    logic cmd_y_ok;
    logic rd_ok;
    logic [3:0] rd_xi;
    logic [4:0] rd_yi;

    assign cmd_x_ok = (cmd_x < COLS_L);
    assign cmd_y_ok = (cmd_y < ROWS_L);

    // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready; cmd_ready is
    // high only in IDLE, and command fields are sampled at that edge only.
    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign lines_total = lines_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        lines_d = lines_q;
        occ_d   = occ_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE, OP_ERASE: begin
                            done_d = 1'b1;
                            if (cmd_x_ok && cmd_y_ok) begin
                                occ_d[cmd_y][cmd_x] = (cmd_op == OP_WRITE);
                                col_d[cmd_y][cmd_x] = (cmd_op == OP_WRITE) ? cmd_color : '0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            ptr_d   = '0;
                            state_d = S_CLEAR;
                        end
                        default: begin
                            if (cmd_y_ok) begin
                                ptr_d   = cmd_y;
                                state_d = S_SHIFT;
                            end else begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_CLEAR: begin
                occ_d[ptr_q] = '0;
                col_d[ptr_q] = '0;
                if (ptr_q == LAST_ROW) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end
            S_SHIFT: begin
                // Walk upward from the collapsed row, pulling each row down by one.
                if (ptr_q == 5'd0) begin
                    occ_d[0] = '0;
                    col_d[0] = '0;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    if (lines_q != 8'hFF) begin
                        lines_d = lines_q + 8'd1;
                    end
                end else begin
                    occ_d[ptr_q] = occ_q[ptr_q - 5'd1];
                    col_d[ptr_q] = col_q[ptr_q - 5'd1];
                    ptr_d        = ptr_q - 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lines_q <= '0;
            occ_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lines_q <= lines_d;
            occ_q   <= occ_d;
            col_q   <= col_d;
        end
    end

    // Out-of-range reads are steered to cell (0,0) and then masked to zero.
    assign rd_ok       = (rd_x < COLS_L) && (rd_y < ROWS_L);
    assign rd_xi       = rd_ok ? rd_x : 4'd0;
    assign rd_yi       = rd_ok ? rd_y : 5'd0;
    assign rd_occupied = rd_ok & occ_q[rd_yi][rd_xi];
    assign rd_color    = rd_ok ? col_q[rd_yi][rd_xi] : '0;

    always_comb begin
        full_rows = '0;
        for (int r = 0; r < ROWS; r++) begin
            full_rows[r] = &occ_q[r];
        end
    end

    err_implies_done: assert property (@(posedge clk) disable iff (!reset_n) err_q |-> done_q);
    ptr_in_range:     assert property (@(posedge clk) disable iff (!reset_n) ptr_q < ROWS_L);

endmodule

// File: tb/tb_playfield_grid_writer.sv
// Bench for playfield_grid_writer: vector table, hand-written multi-cycle sequences and
// randomized commands checked against a command-level grid model.
module tb_playfield_grid_writer;

    localparam int COLS    = 10;
    localparam int ROWS    = 18;
    localparam int COLOR_W = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = '0;
    logic [3:0]         cmd_x = '0;
    logic [4:0]         cmd_y = '0;
    logic [COLOR_W-1:0] cmd_color = '0;
    logic               done;
    logic               err;
    logic               busy;
    logic [3:0]         rd_x = '0;
    logic [4:0]         rd_y = '0;
    logic               rd_occupied;
    logic [COLOR_W-1:0] rd_color;
    logic [ROWS-1:0]    full_rows;
    logic [7:0]         lines_total;

    playfield_grid_writer #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
        .done(done), .err(err), .busy(busy),
        .rd_x(rd_x), .rd_y(rd_y), .rd_occupied(rd_occupied), .rd_color(rd_color),
        .full_rows(full_rows), .lines_total(lines_total)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Command-level reference model of the grid.
    bit                 m_occ[ROWS][COLS];
    logic [COLOR_W-1:0] m_col[ROWS][COLS];
    int                 m_lines;
    logic [1:0]         exp_q[$];

    typedef struct {
        int         op;
        int         x;
        int         y;
        int         c;
        logic       exp_err;
        int         exp_busy;
        int         rx;
        int         ry;
        logic       exp_occ;
        logic [2:0] exp_col;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_occ[r][c] = 1'b0;
                m_col[r][c] = '0;
            end
    endfunction

    function automatic void m_apply(input int op, input int x, input int y, input int c,
                                    output logic e, output int bcy);
        e = 1'b0;
        bcy = 0;
        if (op <= 1) begin
            if (x < COLS && y < ROWS) begin
                m_occ[y][x] = (op == 0);
                m_col[y][x] = (op == 0) ? COLOR_W'(c) : '0;
            end else e = 1'b1;
        end else if (op == 2) begin
            m_clear();
            bcy = ROWS;
        end else begin
            if (y < ROWS) begin
                for (int r = y; r > 0; r--)
                    for (int k = 0; k < COLS; k++) begin
                        m_occ[r][k] = m_occ[r-1][k];
                        m_col[r][k] = m_col[r-1][k];
                    end
                for (int k = 0; k < COLS; k++) begin
                    m_occ[0][k] = 1'b0;
                    m_col[0][k] = '0;
                end
                m_lines = (m_lines < 255) ? m_lines + 1 : 255;
                bcy = y + 1;
            end else e = 1'b1;
        end
    endfunction

    function automatic logic [ROWS-1:0] m_full();
        logic [ROWS-1:0] f;
        for (int r = 0; r < ROWS; r++) begin
            f[r] = 1'b1;
            for (int k = 0; k < COLS; k++) if (!m_occ[r][k]) f[r] = 1'b0;
        end
        return f;
    endfunction

    task automatic apply_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_clear();
        m_lines = 0;
    endtask

    task automatic rd(input int x, input int y, output logic o, output logic [COLOR_W-1:0] c);
        rd_x = 4'(x);
        rd_y = 5'(y);
        #1;
        o = rd_occupied;
        c = rd_color;
    endtask

    // Issues one command, then follows it to completion; ends 1ns after a rising edge.
    task automatic do_cmd(input int op, input int x, input int y, input int c,
                          output int bcy, output logic d, output logic e, output int extra);
        int guard;
        @(posedge clk);
        #1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_x     = 4'(x);
        cmd_y     = 5'(y);
        cmd_color = COLOR_W'(c);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_x     = 4'($urandom);
        cmd_y     = 5'($urandom);
        cmd_color = COLOR_W'($urandom);
        bcy   = 0;
        extra = 0;
        while (busy && bcy < 100) begin
            if (done) extra++;
            @(posedge clk);
            #1;
            bcy++;
        end
        d = done;
        e = err;
        @(posedge clk);
        #1;
        if (done || err) extra++;
    endtask

    task automatic sweep();
        logic o;
        logic [COLOR_W-1:0] c;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                rd(x, y, o, c);
                check($sformatf("sweep_occ(%0d,%0d)", x, y), o, m_occ[y][x]);
                check($sformatf("sweep_col(%0d,%0d)", x, y), c, m_col[y][x]);
            end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bcy, extra, cyc, bad;
        logic d, e, o, me;
        logic [COLOR_W-1:0] c;
        logic [1:0] exp_de;

        vecs[0]  = '{0,  3,  5, 6, 1'b0,  0,  3,  5, 1'b1, 3'd6};
        vecs[1]  = '{0,  0,  0, 1, 1'b0,  0,  3,  6, 1'b0, 3'd0};
        vecs[2]  = '{1,  3,  5, 7, 1'b0,  0,  3,  5, 1'b0, 3'd0};
        vecs[3]  = '{0, 10,  5, 7, 1'b1,  0,  0,  0, 1'b1, 3'd1};
        vecs[4]  = '{0,  2, 18, 7, 1'b1,  0,  2, 17, 1'b0, 3'd0};
        vecs[5]  = '{3,  0, 20, 0, 1'b1,  0,  0,  0, 1'b1, 3'd1};
        vecs[6]  = '{0,  9, 17, 7, 1'b0,  0,  9, 17, 1'b1, 3'd7};
        vecs[7]  = '{3,  0, 17, 0, 1'b0, 18,  0,  1, 1'b1, 3'd1};
        vecs[8]  = '{0,  4,  4, 3, 1'b0,  0,  9, 17, 1'b0, 3'd0};
        vecs[9]  = '{2,  5,  5, 5, 1'b0, 18,  0,  1, 1'b0, 3'd0};
        vecs[10] = '{0,  2,  2, 5, 1'b0,  0, 15,  2, 1'b0, 3'd0};
        vecs[11] = '{3,  0,  0, 0, 1'b0,  1,  2,  2, 1'b1, 3'd5};
        vecs[12] = '{1, 12,  2, 0, 1'b1,  0,  2,  2, 1'b1, 3'd5};

        apply_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_lines", lines_total, 8'd0);
        check("rst_full", full_rows, '0);
        rd(3, 5, o, c);
        check("rst_rd_occ", o, 1'b0);

        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].c, bcy, d, e, extra);
            check($sformatf("vec%0d_busy", i), bcy, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), d, 1'b1);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("vec%0d_pulse", i), extra, 0);
            rd(vecs[i].rx, vecs[i].ry, o, c);
            check($sformatf("vec%0d_occ", i), o, vecs[i].exp_occ);
            check($sformatf("vec%0d_col", i), c, vecs[i].exp_col);
        end
        check("vec_lines", lines_total, 8'd2);

        // Back-to-back fill of row 17, then collapse it away.
        apply_reset();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_y     = 5'd17;
        cmd_color = 3'd4;
        for (int i = 0; i < COLS; i++) begin
            cmd_x = 4'(i);
            @(posedge clk);
            #1;
            check($sformatf("fill%0d_full17", i), full_rows[17], (i == COLS - 1));
            check($sformatf("fill%0d_done", i), done, 1'b1);
        end
        cmd_valid = 1'b0;
        do_cmd(0, 0, 16, 2, bcy, d, e, extra);
        check("pre_collapse_full", full_rows, 18'h20000);
        do_cmd(3, 0, 17, 0, bcy, d, e, extra);
        check("col17_busy", bcy, 18);
        check("col17_done", d, 1'b1);
        check("col17_pulse", extra, 0);
        check("col17_lines", lines_total, 8'd1);
        check("col17_full", full_rows, '0);
        rd(0, 17, o, c);
        check("col17_occ", o, 1'b1);
        check("col17_col", c, 3'd2);
        rd(1, 17, o, c);
        check("col17_occ_x1", o, 1'b0);
        bad = 0;
        for (int k = 0; k < COLS; k++) begin
            rd(k, 0, o, c);
            if (o || c != 0) bad++;
        end
        check("col17_row0_empty", bad, 0);

        // A write held valid across a collapse waits for cmd_ready.
        do_cmd(0, 1, 3, 5, bcy, d, e, extra);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_y     = 5'd4;
        @(posedge clk);
        #1;
        cmd_op    = 2'b00;
        cmd_x     = 4'd1;
        cmd_y     = 5'd0;
        cmd_color = 3'd3;
        cyc = 0;
        bad = 0;
        while (busy && cyc < 50) begin
            if (cmd_ready || done) bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold_busy", cyc, 5);
        check("hold_ready_done", bad, 0);
        check("hold_col_done", done, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("hold_wr_done", done, 1'b1);
        rd(1, 0, o, c);
        check("hold_wr_occ", o, 1'b1);
        check("hold_wr_col", c, 3'd3);
        rd(1, 4, o, c);
        check("hold_shift_col", c, 3'd5);
        rd(1, 3, o, c);
        check("hold_shift_empty", o, 1'b0);
        check("hold_lines", lines_total, 8'd2);

        // Asynchronous reset partway through a collapse.
        do_cmd(0, 5, 10, 1, bcy, d, e, extra);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_y     = 5'd10;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_lines", lines_total, 8'd0);
        check("arst_full", full_rows, '0);
        rd(5, 11, o, c);
        check("arst_occ", o, 1'b0);
        rd(0, 17, o, c);
        check("arst_occ17", o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) bad++;
        end
        check("arst_no_done", bad, 0);
        check("arst_ready", cmd_ready, 1'b1);
        m_clear();
        m_lines = 0;

        // Saturation of the lines counter.
        for (int i = 0; i < 256; i++) begin
            do_cmd(3, 0, 0, 0, bcy, d, e, extra);
            if (i == 0) check("sat_busy", bcy, 1);
            if (i == 99) check("sat_lines100", lines_total, 8'd100);
            if (i == 254) check("sat_lines255", lines_total, 8'd255);
        end
        check("sat_lines256", lines_total, 8'd255);

        // Randomized commands against the model.
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            int k, op, x, y, cc, mb, ex, ey;
            k  = $urandom_range(0, 99);
            op = (k < 55) ? 0 : (k < 75) ? 1 : (k < 80) ? 2 : 3;
            if (n == 150) op = 2;
            x  = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            if ($urandom_range(0, 19) == 0) y = $urandom_range(18, 31);
            else if ($urandom_range(0, 2) != 0) y = $urandom_range(12, 17);
            else y = $urandom_range(0, 17);
            cc = $urandom_range(0, 7);
            m_apply(op, x, y, cc, me, mb);
            exp_q.push_back({1'b1, me});
            do_cmd(op, x, y, cc, bcy, d, e, extra);
            exp_de = exp_q.pop_front();
            check($sformatf("rnd%0d_done", n), d, exp_de[1]);
            check($sformatf("rnd%0d_err", n), e, exp_de[0]);
            check($sformatf("rnd%0d_busy", n), bcy, mb);
            check($sformatf("rnd%0d_pulse", n), extra, 0);
            check($sformatf("rnd%0d_lines", n), lines_total, m_lines);
            check($sformatf("rnd%0d_full", n), full_rows, m_full());
            for (int j = 0; j < 2; j++) begin
                ex = $urandom_range(0, 11);
                ey = $urandom_range(0, 19);
                rd(ex, ey, o, c);
                check($sformatf("rnd%0d_occ(%0d,%0d)", n, ex, ey), o,
                      (ex < COLS && ey < ROWS) ? m_occ[ey][ex] : 1'b0);
                check($sformatf("rnd%0d_col(%0d,%0d)", n, ex, ey), c,
                      (ex < COLS && ey < ROWS) ? m_col[ey][ex] : 3'd0);
            end
            if (n % 75 == 74 || n == 151) sweep();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
